// File: rtl/if_id_fetch_queue.sv
// IF/ID fetch queue: DEPTH-entry FIFO of {instruction, PC} pairs between
// fetch and decode, with valid/ready handshakes, redirect flush and a NOP
// bubble toward decode whenever the queue is empty.
module if_id_fetch_queue #(
  parameter int unsigned             INSTR_WIDTH = 32,
  parameter int unsigned             PC_WIDTH    = 32,
  parameter int unsigned             DEPTH       = 4,
  parameter logic [INSTR_WIDTH-1:0]  NOP_WORD    = '0
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INSTR_WIDTH-1:0]        in_instr,
  input  logic [PC_WIDTH-1:0]           in_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INSTR_WIDTH-1:0]        out_instr,
  output logic [PC_WIDTH-1:0]           out_pc,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
  logic [PC_WIDTH-1:0]    pc_mem    [DEPTH];
  logic [AW-1:0]          rd_ptr;
  logic [AW-1:0]          wr_ptr;
  logic [CW-1:0]          occ;
  logic                   push;
  logic                   pop;
  logic                   clear;

  // Handshake status derives only from registered occupancy, so a full
  // queue refuses a push even when decode pops in the same cycle.
  always_comb begin
    in_ready  = (occ != CW'(DEPTH));
    out_valid = (occ != CW'(0));
    clear     = Reset || flush;
    push      = in_valid && in_ready && !clear;
    pop       = out_valid && out_ready && !clear;
    count     = occ;
  end

  // Head presentation: stored entry when valid, NOP bubble otherwise.
  always_comb begin
    out_instr = NOP_WORD;
    out_pc    = '0;
    if (out_valid) begin
      out_instr = instr_mem[rd_ptr];
      out_pc    = pc_mem[rd_ptr];
    end
  end

  // Pointer and occupancy tracking; reset and flush both empty the queue.
  always_ff @(posedge Clk) begin
    if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Entry storage; contents are never cleared, the pointers define validity.
  always_ff @(posedge Clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= in_instr;
      pc_mem[wr_ptr]    <= in_pc;
    end
  end

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Directed bench for if_id_fetch_queue: reset, fill/drain, streaming with
// pointer wrap, flush, full-with-pop and reset mid-stream.
module tb_if_id_fetch_queue;

  logic        Clk;
  logic        Reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  count;

  int errors;
  int checks;

  if_id_fetch_queue #(
    .INSTR_WIDTH (32),
    .PC_WIDTH    (32),
    .DEPTH       (4),
    .NOP_WORD    (32'h0000_0000)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .count     (count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".count"},     64'(count),     64'd0);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".out_instr"}, 64'(out_instr), 64'h0);
    chk({tag, ".out_pc"},    64'(out_pc),    64'h0);
    chk({tag, ".in_ready"},  64'(in_ready),  64'd1);
  endtask

  logic [31:0] fill_instr [4];
  logic [31:0] exp_pc;

  initial begin
    errors    = 0;
    checks    = 0;
    Reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b0;

    // Reset then idle
    tick();
    tick();
    chk_empty("reset");
    Reset = 1'b0;
    tick();
    chk_empty("idle");

    // Fill with out_ready low
    fill_instr[0] = 32'h2008_0001;
    fill_instr[1] = 32'h2009_0002;
    fill_instr[2] = 32'h012A_5020;
    fill_instr[3] = 32'hAC0A_0000;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_instr = fill_instr[i];
      in_pc    = 32'(4 * i);
      tick();
      if (i == 0) begin
        chk("fill.latency_valid", 64'(out_valid), 64'd1);
        chk("fill.latency_instr", 64'(out_instr), 64'h2008_0001);
      end
    end
    chk("fill.count4",  64'(count),    64'd4);
    chk("fill.inready", 64'(in_ready), 64'd0);

    // Fifth push must be rejected
    in_instr = 32'hFFFF_FFFF;
    in_pc    = 32'h10;
    tick();
    chk("overflow.count", 64'(count),     64'd4);
    chk("overflow.head",  64'(out_instr), 64'h2008_0001);

    // Drain in order
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d.instr", i), 64'(out_instr), 64'(fill_instr[i]));
      chk($sformatf("drain%0d.pc", i),    64'(out_pc),    64'(4 * i));
      tick();
    end
    chk_empty("drained");

    // Streaming push+pop every cycle, pointers wrap twice
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_pc    = 32'h100 + 32'(4 * k);
      in_instr = 32'h0000_1000 + 32'(k);
      tick();
      exp_pc = 32'h100 + 32'(4 * k);
      chk($sformatf("stream%0d.count", k), 64'(count),     64'd1);
      chk($sformatf("stream%0d.pc", k),    64'(out_pc),    64'(exp_pc));
      chk($sformatf("stream%0d.instr", k), 64'(out_instr), 64'(32'h1000 + 32'(k)));
    end
    in_valid = 1'b0;
    tick();
    chk("stream.end_count", 64'(count), 64'd0);

    // Flush with same-cycle push and pop
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_pc    = 32'h40 + 32'(4 * i);
      in_instr = 32'hA000_0000 + 32'(i);
      tick();
    end
    chk("preflush.count", 64'(count), 64'd3);
    flush     = 1'b1;
    in_pc     = 32'h4C;
    in_instr  = 32'hA000_0003;
    out_ready = 1'b1;
    tick();
    chk_empty("flush");
    flush     = 1'b0;
    out_ready = 1'b0;
    in_pc     = 32'h80;
    in_instr  = 32'hB000_0000;
    tick();
    in_valid = 1'b0;
    chk("postflush.pc",    64'(out_pc), 64'h80);
    chk("postflush.count", 64'(count),  64'd1);
    out_ready = 1'b1;
    tick();
    chk("postflush.empty", 64'(out_valid), 64'd0);

    // Full queue with simultaneous push and pop
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_pc    = 32'h200 + 32'(4 * i);
      in_instr = 32'hC000_0000 + 32'(i);
      tick();
    end
    chk("full.count", 64'(count), 64'd4);
    in_pc     = 32'h210;
    in_instr  = 32'hC000_0004;
    out_ready = 1'b1;
    tick();
    chk("fullpop.count", 64'(count),  64'd3);
    chk("fullpop.head",  64'(out_pc), 64'h204);
    tick();
    chk("fullpop2.count", 64'(count),  64'd3);
    chk("fullpop2.head",  64'(out_pc), 64'h208);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("fulldrain%0d.pc", i), 64'(out_pc), 64'(32'h208 + 32'(4 * i)));
      tick();
    end
    chk("fulldrain.count", 64'(count), 64'd0);

    // Reset mid-stream with a same-cycle push
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h300;
    in_instr  = 32'hD000_0000;
    tick();
    in_pc     = 32'h304;
    in_instr  = 32'hD000_0001;
    tick();
    chk("premidrst.count", 64'(count), 64'd2);
    Reset    = 1'b1;
    in_pc    = 32'h308;
    in_instr = 32'hD000_0002;
    tick();
    chk_empty("midrst");
    Reset    = 1'b0;
    in_pc    = 32'h400;
    in_instr = 32'hE000_0000;
    tick();
    in_valid = 1'b0;
    chk("postrst.pc",    64'(out_pc),    64'h400);
    chk("postrst.instr", 64'(out_instr), 64'hE000_0000);
    chk("postrst.count", 64'(count),     64'd1);
    out_ready = 1'b1;
    tick();
    chk("postrst.empty", 64'(out_valid), 64'd0);

    // Reset and flush together behave as reset
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h500;
    tick();
    Reset = 1'b1;
    flush = 1'b1;
    tick();
    Reset    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk_empty("rstflush");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_id_fetch_queue.md
Name: if_id_fetch_queue

Overview:
- Parametrised successor to the single-entry IF/ID instruction register.
- Sits between the fetch stage (IF) and decode stage (ID) as a DEPTH-entry FIFO of {instruction, PC} pairs.
- Provides valid/ready handshakes on both sides, a flush for branch/jump redirect, and a NOP bubble to ID whenever it is empty.
- Decouples I-fetch from decode stalls.

Parameters:
- INSTR_WIDTH, 32, width of the instruction word.
- PC_WIDTH, 32, width of the captured PC.
- DEPTH, 4, number of queue entries; must be a power of 2 and >= 2.
- NOP_WORD, 32'h0000_0000, value driven on out_instr when the queue is empty (must fit in INSTR_WIDTH).

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- flush  input  1  discard all queued entries (redirect from branch/jump resolution).
- in_valid  input  1  IF presents a fetched instruction.
- in_ready  output  1  queue can accept a push this cycle.
- in_instr  input  INSTR_WIDTH  fetched instruction.
- in_pc  input  PC_WIDTH  PC of in_instr.
- out_valid  output  1  head entry is valid for ID.
- out_ready  input  1  ID consumes the head this cycle (ID writeEnable).
- out_instr  output  INSTR_WIDTH  head instruction, or NOP_WORD when empty.
- out_pc  output  PC_WIDTH  head PC, or 0 when empty.
- count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH-entry register array plus rd_ptr and wr_ptr of clog2(DEPTH) bits, wrapping modulo DEPTH, and a registered occupancy counter.
- Push condition: in_valid && in_ready.
- Pop condition: out_valid && out_ready.
- in_ready = (count != DEPTH).
  - Combinational only from state, never from out_ready.
  - A full queue therefore refuses a push even when a pop occurs in the same cycle.
- out_valid = (count != 0).
- out_instr / out_pc are read from entry[rd_ptr] when out_valid = 1, otherwise NOP_WORD / 0. There is no combinational path from in_* to out_*.
- Latency: an instruction pushed at edge N appears on out_* after edge N (one cycle), including when the queue was empty. There is no bypass.
- Simultaneous push and pop with 0 < count < DEPTH: both occur, count is unchanged, and both pointers advance.
- Pop while empty is ignored; count stays 0.
- Push while full is ignored: in_ready = 0 and the entry is not written.
- FIFO order: entries leave in exactly push order. Pointer wrap from DEPTH-1 to 0 is seamless.
- Flush (sampled at the edge): rd_ptr, wr_ptr and count go to 0.
  - A same-cycle push is dropped and a same-cycle pop has no effect.
  - The next cycle shows out_valid = 0, out_instr = NOP_WORD, in_ready = 1.
  - Flush takes priority over push and pop.
- Reset (synchronous, highest priority): same effect as flush. After the edge: count = 0, out_valid = 0, in_ready = 1, out_instr = NOP_WORD, out_pc = 0.
  - Storage contents need not be cleared.
  - Reset mid-operation discards all entries.
- Reset and flush asserted together behave as reset.
- Inputs are sampled only at the rising edge of Clk; the block has no asynchronous behaviour.

Test Plan:
- Reset then idle: assert Reset for 2 cycles → count = 0, out_valid = 0, out_instr = 32'h0, out_pc = 0, in_ready = 1.
- Fill and drain, out_ready = 0:
  - Push {0x20080001 @ pc 0x00}, {0x20090002 @ 0x04}, {0x012A5020 @ 0x08}, {0xAC0A0000 @ 0x0C} → count = 4, in_ready = 0.
  - A 5th push {0xFFFFFFFF @ 0x10} is rejected.
  - Raise out_ready → exactly the 4 words appear in order on consecutive cycles, then out_valid = 0 and out_instr = NOP_WORD.
- Streaming: in_valid = 1 and out_ready = 1 continuously with PC incrementing by 4 from 0x100, for 10 cycles → count holds at 1 after the first cycle. Output PC sequence is 0x100, 0x104, … with one-cycle latency and rd_ptr wrapping twice without loss.
- Flush:
  - Queue holds 3 entries (pc 0x40, 0x44, 0x48).
  - Assert flush together with in_valid (pc 0x4C) and out_ready.
  - Required: next cycle count = 0, out_valid = 0, the 0x4C push is dropped.
  - A following push of pc 0x80 emerges next, and 0x44/0x48 never appear.
- Full with simultaneous pop: count = 4, in_valid = 1, out_ready = 1 → one pop occurs, no push, count = 3. The next cycle the push succeeds and count = 3 again.
- Reset mid-stream: with count = 2, assert Reset for 1 cycle together with in_valid → count = 0, out_valid = 0, in_ready = 1. Stale entries are never presented after subsequent pushes.
